// File: rtl/reg_read_stage.sv
// reg_read_stage: rs1/rs2 operand select with same-cycle write-back bypass,
// load-use stall tracking and a valid/ready ID/EX pipeline register.
module reg_read_stage #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [(2**ADDR_W)*WIDTH-1:0]  regs_flat,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_W-1:0]             rs1_addr,
  input  logic [ADDR_W-1:0]             rs2_addr,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic                          in_reg_write,
  input  logic                          in_is_load,
  input  logic                          wb_reg_write,
  input  logic [ADDR_W-1:0]             wb_rd,
  input  logic [WIDTH-1:0]              wb_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              rs1_data,
  output logic [WIDTH-1:0]              rs2_data,
  output logic [ADDR_W-1:0]             out_rd,
  output logic                          out_reg_write,
  output logic                          out_is_load
);
  localparam int NREG = 2**ADDR_W;
  logic [WIDTH-1:0]  regs [NREG];
  logic [NREG-1:0]   pend_q, pend_d, pend_set, pend_clr;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [ADDR_W-1:0] out_rd_q, out_rd_d;
  logic              out_reg_write_q, out_reg_write_d, out_is_load_q, out_is_load_d;
  logic              rs1_byp, rs2_byp, hazard, cap;
  logic [WIDTH-1:0]  rs1_sel, rs2_sel;
  genvar i;
  generate
    for (i = 0; i < NREG; i++) begin : g_regs
      assign regs[i] = regs_flat[i*WIDTH +: WIDTH];
    end
  endgenerate
  // x0 is writable in the file, so zero is forced here rather than trusted
  always_comb begin
    rs1_byp         = wb_reg_write && wb_rd == rs1_addr;
    rs2_byp         = wb_reg_write && wb_rd == rs2_addr;
    rs1_sel         = rs1_addr == '0 ? '0 : rs1_byp ? wb_data : regs[rs1_addr];
    rs2_sel         = rs2_addr == '0 ? '0 : rs2_byp ? wb_data : regs[rs2_addr];
    hazard          = (rs1_addr != '0 && pend_q[rs1_addr] && !rs1_byp) ||
                      (rs2_addr != '0 && pend_q[rs2_addr] && !rs2_byp);
    in_ready        = (!out_valid_q || out_ready) && !hazard && !flush;
    cap             = in_valid && in_ready;
    pend_clr        = wb_reg_write ? (NREG'(1) << wb_rd) : '0;
    pend_set        = (cap && in_is_load && in_reg_write && rd_addr != '0) ? (NREG'(1) << rd_addr) : '0;
    pend_d          = (pend_q & ~pend_clr) | pend_set;
    out_valid_d     = cap || (out_valid_q && !out_ready && !flush);
    rs1_data_d      = cap ? rs1_sel : rs1_data_q;
    rs2_data_d      = cap ? rs2_sel : rs2_data_q;
    out_rd_d        = cap ? rd_addr : out_rd_q;
    out_reg_write_d = cap ? in_reg_write : out_reg_write_q;
    out_is_load_d   = cap ? in_is_load : out_is_load_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q          <= '0;
      out_valid_q     <= 1'b0;
      rs1_data_q      <= '0;
      rs2_data_q      <= '0;
      out_rd_q        <= '0;
      out_reg_write_q <= 1'b0;
      out_is_load_q   <= 1'b0;
    end else begin
      pend_q          <= pend_d;
      out_valid_q     <= out_valid_d;
      rs1_data_q      <= rs1_data_d;
      rs2_data_q      <= rs2_data_d;
      out_rd_q        <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
      out_is_load_q   <= out_is_load_d;
    end
  end
  assign out_valid     = out_valid_q;
  assign rs1_data      = rs1_data_q;
  assign rs2_data      = rs2_data_q;
  assign out_rd        = out_rd_q;
  assign out_reg_write = out_reg_write_q;
  assign out_is_load   = out_is_load_q;
endmodule

// File: tb/tb_reg_read_stage.sv
// tb_reg_read_stage: table-driven vectors through a scoreboard, plus
// load-use, back-pressure, flush and reset-mid-hold sequences.
module tb_reg_read_stage;
  localparam int W = 32;
  localparam int A = 5;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [32*W-1:0] regs_flat;
  logic in_valid, in_ready, in_reg_write, in_is_load, wb_reg_write, flush;
  logic out_valid, out_ready, out_reg_write, out_is_load;
  logic [A-1:0] rs1_addr, rs2_addr, rd_addr, wb_rd, out_rd;
  logic [W-1:0] wb_data, rs1_data, rs2_data;
  typedef struct packed {
    logic [4:0]  rd;
    logic        wr, ld;
    logic [31:0] d1, d2;
  } exp_t;
  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        wr, ld, wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd, e1, e2;
  } vec_t;
  exp_t sb[$];
  exp_t cur, got;
  vec_t tbl[6];
  int n_cmp = 0;
  int n_bad = 0;
  bit sb_on = 1'b0;
  always #5 clk = ~clk;
  reg_read_stage #(.WIDTH(W), .ADDR_W(A)) dut (
    .clk(clk), .reset(reset), .regs_flat(regs_flat),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .in_reg_write(in_reg_write), .in_is_load(in_is_load),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_is_load(out_is_load)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic drive(input logic [4:0] r1, r2, rd, input logic wr, ld, input logic [31:0] e1, e2);
    in_valid = 1'b1; rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
    in_reg_write = wr; in_is_load = ld;
    cur = '{rd: rd, wr: wr, ld: ld, d1: e1, d2: e2};
  endtask
  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_reg_write = en; wb_rd = r; wb_data = d;
  endtask
  always @(negedge clk) if (sb_on) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow: got output rd=%0d, expected no output", out_rd);
      end else begin
        got = sb.pop_front();
        chk("sb_rs1_data", rs1_data, got.d1);
        chk("sb_rs2_data", rs2_data, got.d2);
        chk("sb_out_rd", {27'd0, out_rd}, {27'd0, got.rd});
        chk("sb_ctrl", {30'd0, out_reg_write, out_is_load}, {30'd0, got.wr, got.ld});
      end
    end
    if (flush && out_valid && !out_ready && sb.size() > 0) void'(sb.pop_back());
    if (in_valid && in_ready) sb.push_back(cur);
  end
  initial begin
    for (int n = 0; n < 32; n++) regs_flat[n*32 +: 32] = 32'h1000_0000 + n;
    regs_flat[31:0]    = 32'hDEAD_BEEF;
    regs_flat[5*32 +: 32] = 32'h11;
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0; in_reg_write = 0; in_is_load = 0;
    wb(0, 0, 0); flush = 0; out_ready = 1; cur = '0;
    tbl[0] = '{rs1: 1,  rs2: 2,  rd: 3,  wr: 1, ld: 0, wbe: 0, wbr: 0,  wbd: 0,        e1: 32'h1000_0001, e2: 32'h1000_0002};
    tbl[1] = '{rs1: 0,  rs2: 0,  rd: 4,  wr: 1, ld: 0, wbe: 0, wbr: 0,  wbd: 0,        e1: 32'h0,         e2: 32'h0};
    tbl[2] = '{rs1: 5,  rs2: 5,  rd: 1,  wr: 0, ld: 0, wbe: 1, wbr: 5,  wbd: 32'h1234, e1: 32'h1234,      e2: 32'h1234};
    tbl[3] = '{rs1: 5,  rs2: 6,  rd: 2,  wr: 1, ld: 0, wbe: 1, wbr: 6,  wbd: 32'hABCD, e1: 32'h11,        e2: 32'hABCD};
    tbl[4] = '{rs1: 0,  rs2: 3,  rd: 0,  wr: 1, ld: 0, wbe: 1, wbr: 0,  wbd: 32'hFFFF, e1: 32'h0,         e2: 32'h1000_0003};
    tbl[5] = '{rs1: 31, rs2: 30, rd: 31, wr: 0, ld: 0, wbe: 1, wbr: 29, wbd: 32'h7777, e1: 32'h1000_001F, e2: 32'h1000_001E};
    cyc; cyc;
    mid;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rs1_data", rs1_data, 0);
    chk("rst_pend", dut.pend_q, 0);
    cyc;
    reset = 1;
    sb_on = 1;
    foreach (tbl[i]) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wr, tbl[i].ld, tbl[i].e1, tbl[i].e2);
      wb(tbl[i].wbe, tbl[i].wbr, tbl[i].wbd);
      mid; chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      cyc;
    end
    in_valid = 0; wb(0, 0, 0);
    mid; cyc;
    drive(1, 2, 7, 1, 1, 32'h1000_0001, 32'h1000_0002);
    mid; chk("lu_issue_ready", in_ready, 1);
    cyc;
    drive(3, 7, 8, 1, 0, 32'h1000_0003, 32'hCAFE);
    mid; chk("lu_stall1_ready", in_ready, 0); chk("lu_stall1_valid", out_valid, 1);
    cyc;
    mid; chk("lu_stall2_ready", in_ready, 0); chk("lu_bubble", out_valid, 0);
    cyc;
    wb(1, 7, 32'hCAFE);
    mid; chk("lu_wb_ready", in_ready, 1);
    cyc;
    in_valid = 0; wb(0, 0, 0);
    mid; chk("lu_pend7", dut.pend_q[7], 0); chk("lu_out_valid", out_valid, 1);
    cyc;
    drive(1, 2, 3, 1, 0, 32'h1000_0001, 32'h1000_0002);
    mid; cyc;
    out_ready = 0;
    drive(4, 5, 6, 0, 0, 32'h1000_0004, 32'h11);
    for (int k = 0; k < 4; k++) begin
      mid;
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
      chk($sformatf("bp%0d_valid", k), out_valid, 1);
      chk($sformatf("bp%0d_rs1", k), rs1_data, 32'h1000_0001);
      chk($sformatf("bp%0d_rd", k), {27'd0, out_rd}, 3);
      cyc;
    end
    out_ready = 1;
    mid; chk("bp_release_ready", in_ready, 1);
    cyc;
    in_valid = 0;
    mid; chk("bp_next_rd", {27'd0, out_rd}, 6);
    cyc;
    drive(0, 0, 12, 1, 1, 32'h0, 32'h0);
    mid; cyc;
    out_ready = 0; flush = 1;
    drive(1, 2, 9, 1, 1, 32'h1000_0001, 32'h1000_0002);
    mid; chk("fl_in_ready", in_ready, 0);
    cyc;
    flush = 0; in_valid = 0;
    mid;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_pend9", dut.pend_q[9], 0);
    chk("fl_pend12", dut.pend_q[12], 1);
    cyc;
    out_ready = 1;
    drive(12, 0, 12, 1, 1, 32'h5A5A, 32'h0);
    mid; chk("hz_rs1_ready", in_ready, 0);
    cyc;
    wb(1, 12, 32'h5A5A);
    mid; chk("hz_wb_ready", in_ready, 1);
    cyc;
    in_valid = 0; wb(0, 0, 0); out_ready = 0;
    mid; chk("set_wins_pend12", dut.pend_q[12], 1); chk("hold_valid", out_valid, 1);
    cyc;
    reset = 0;
    mid;
    chk("rh_out_valid", out_valid, 0);
    chk("rh_rs1_data", rs1_data, 0);
    chk("rh_rs2_data", rs2_data, 0);
    chk("rh_out_rd", {27'd0, out_rd}, 0);
    chk("rh_ctrl", {30'd0, out_reg_write, out_is_load}, 0);
    chk("rh_pend", dut.pend_q, 0);
    sb.delete();
    cyc;
    reset = 1; out_ready = 1;
    mid; chk("rh_after_valid", out_valid, 0); chk("rh_after_pend", dut.pend_q, 0);
    cyc;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
